// File: rtl/parking_slot_allocator.sv
// parking_slot_allocator
// Purpose : 8-slot parking occupancy tracker. Serves one enter or exit request
//           at a time through an IDLE/EVAL/COMMIT/RESP FSM. The occupancy update
//           goes out through an external next-capacity stage (park_location out,
//           new_capacity back in).
// Latency : accepted grant -> resp_valid 3 cycles later; reject -> 2 cycles later.
// Backpr. : requests are held by the requester until accepted. A request is
//           accepted on a clk edge with req_ready=1, which is only high in IDLE.
//           Exit wins over a simultaneous enter; the enter stays pending.
// Ports   : clk, rst (async, active-high); enter_req, exit_req, exit_slot[2:0];
//           req_ready; park_location[7:0] / new_capacity[7:0] to and from the
//           next-capacity stage; parking_capacity[7:0]; resp_valid, resp_slot[2:0],
//           resp_ok; full, free_count[3:0]; check_err.
// Option  : define PARK_ALLOC_CHECK_EN to verify new_capacity against the
//           expected toggle. On a mismatch: hold occupancy, set sticky check_err,
//           and reject the request.
module parking_slot_allocator (
  input  logic       clk,
  input  logic       rst,
  input  logic       enter_req,
  input  logic       exit_req,
  input  logic [2:0] exit_slot,
  output logic       req_ready,
  output logic [7:0] park_location,
  output logic [7:0] parking_capacity,
  input  logic [7:0] new_capacity,
  output logic       resp_valid,
  output logic [2:0] resp_slot,
  output logic       resp_ok,
  output logic       full,
  output logic [3:0] free_count,
  output logic       check_err
);

  typedef enum logic [1:0] {S_IDLE, S_EVAL, S_COMMIT, S_RESP} state_t;

  state_t     state_q, state_d;
  logic       kind_exit_q, kind_exit_d;
  logic [2:0] slot_q, slot_d;
  logic       ok_q, ok_d;
  logic [7:0] cap_q, cap_d;
  logic       init_q, init_d;   // keeps req_ready low until the first edge after reset
  logic       free_found;
  logic [2:0] free_idx;
  logic [3:0] zero_cnt;
  logic [7:0] commit_mask;

`ifdef PARK_ALLOC_CHECK_EN
  logic       err_q, err_d;
`endif

  // Lowest-index free slot. Scan from high to low so the last hit wins.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    zero_cnt   = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!cap_q[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
        zero_cnt   = zero_cnt + 4'd1;
      end
    end
  end

  assign commit_mask      = 8'b1 << slot_q;
  assign parking_capacity = cap_q;
  assign full             = (cap_q == 8'hFF);
  assign free_count       = zero_cnt;

  always_comb begin
    state_d       = state_q;
    kind_exit_d   = kind_exit_q;
    slot_d        = slot_q;
    ok_d          = ok_q;
    cap_d         = cap_q;
    init_d        = 1'b1;
`ifdef PARK_ALLOC_CHECK_EN
    err_d         = err_q;
`endif
    park_location = 8'h00;
    resp_valid    = 1'b0;
    req_ready     = (state_q == S_IDLE) && init_q;

    case (state_q)
      S_IDLE: begin
        if (req_ready) begin
          if (exit_req) begin
            kind_exit_d = 1'b1;
            slot_d      = exit_slot;
            state_d     = S_EVAL;
          end else if (enter_req) begin
            kind_exit_d = 1'b0;
            slot_d      = 3'd0;
            state_d     = S_EVAL;
          end
        end
      end
      S_EVAL: begin
        if (kind_exit_q) begin
          // Vacating an already-empty slot is rejected; the slot is still reported.
          if (cap_q[slot_q]) begin
            state_d = S_COMMIT;
          end else begin
            ok_d    = 1'b0;
            state_d = S_RESP;
          end
        end else if (free_found) begin
          slot_d  = free_idx;
          state_d = S_COMMIT;
        end else begin
          slot_d  = 3'd0;
          ok_d    = 1'b0;
          state_d = S_RESP;
        end
      end
      S_COMMIT: begin
        park_location = commit_mask;
        state_d       = S_RESP;
`ifdef PARK_ALLOC_CHECK_EN
        if (new_capacity != (cap_q ^ commit_mask)) begin
          err_d = 1'b1;
          ok_d  = 1'b0;
        end else begin
          cap_d = new_capacity;
          ok_d  = 1'b1;
        end
`else
        cap_d = new_capacity;
        ok_d  = 1'b1;
`endif
      end
      S_RESP: begin
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_slot = resp_valid ? slot_q : 3'd0;
  assign resp_ok   = resp_valid & ok_q;

`ifdef PARK_ALLOC_CHECK_EN
  assign check_err = err_q;
`else
  assign check_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      kind_exit_q <= 1'b0;
      slot_q      <= 3'd0;
      ok_q        <= 1'b0;
      cap_q       <= 8'h00;
      init_q      <= 1'b0;
`ifdef PARK_ALLOC_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      kind_exit_q <= kind_exit_d;
      slot_q      <= slot_d;
      ok_q        <= ok_d;
      cap_q       <= cap_d;
      init_q      <= init_d;
`ifdef PARK_ALLOC_CHECK_EN
      err_q       <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_parking_slot_allocator.sv
// tb_parking_slot_allocator
// Purpose : self-checking bench for parking_slot_allocator. Uses a vector table,
//           hand sequences for the corner cases, and random traffic against an
//           occupancy model.
// Ports   : none; the bench acts as the next-capacity stage (toggle, or a forced corruption).
module tb_parking_slot_allocator;
  logic       clk = 1'b0;
  logic       rst, enter_req, exit_req, corrupt;
  logic [2:0] exit_slot;
  logic       req_ready, resp_valid, resp_ok, full, check_err;
  logic [7:0] park_location, parking_capacity, new_capacity;
  logic [2:0] resp_slot;
  logic [3:0] free_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign new_capacity = corrupt ? 8'hAA : (parking_capacity ^ park_location);

  parking_slot_allocator dut (
    .clk(clk), .rst(rst), .enter_req(enter_req), .exit_req(exit_req),
    .exit_slot(exit_slot), .req_ready(req_ready), .park_location(park_location),
    .parking_capacity(parking_capacity), .new_capacity(new_capacity),
    .resp_valid(resp_valid), .resp_slot(resp_slot), .resp_ok(resp_ok),
    .full(full), .free_count(free_count), .check_err(check_err)
  );

  typedef struct {
    bit         is_exit;
    logic [2:0] slot;
    logic [2:0] exp_slot;
    bit         exp_ok;
    logic [7:0] exp_cap;
    logic [7:0] exp_pl;
    int         exp_lat;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_resp(output int lat, output logic [7:0] pl_or, output int pl_n);
    lat = 1; pl_or = 8'h00; pl_n = 0;
    while (!resp_valid && lat < 10) begin
      if (park_location != 8'h00) begin
        pl_or = pl_or | park_location;
        pl_n++;
      end
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) chk("resp_timeout", resp_valid, 1);
  endtask

  // Returns at the negedge of the response cycle.
  task automatic txn(input bit is_exit, input logic [2:0] s, output int lat,
                     output logic [7:0] pl_or, output int pl_n);
    int n;
    @(negedge clk);
    exit_req  = is_exit;
    enter_req = !is_exit;
    exit_slot = s;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("accept_timeout", req_ready, 1);
    @(negedge clk);  // accept edge has passed; now in the cycle after acceptance
    enter_req = 1'b0;
    exit_req  = 1'b0;
    wait_resp(lat, pl_or, pl_n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enter_req = 1'b0; exit_req = 1'b0; corrupt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int lat, pl_n, n;
    logic [7:0] pl_or, occ, exp_pl;
    logic [2:0] s, exp_slot;
    bit is_exit, exp_ok, seen;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b0, 3'd0, 3'(i), 1'b1, 8'((1 << (i + 1)) - 1), 8'(1 << i), 3};
    vecs[8] = '{1'b0, 3'd0, 3'd0, 1'b0, 8'hFF, 8'h00, 2};
    for (int k = 0; k < 5; k++)
      vecs[9 + k] = '{1'b1, 3'(7 - k), 3'(7 - k), 1'b1, 8'(8'hFF >> (k + 1)), 8'(1 << (7 - k)), 3};
    vecs[14] = '{1'b1, 3'd1, 3'd1, 1'b1, 8'h05, 8'h02, 3};
    vecs[15] = '{1'b0, 3'd0, 3'd1, 1'b1, 8'h07, 8'h02, 3};
    vecs[16] = '{1'b1, 3'd1, 3'd1, 1'b1, 8'h05, 8'h02, 3};
    vecs[17] = '{1'b1, 3'd3, 3'd3, 1'b0, 8'h05, 8'h00, 2};

    rst = 1'b1; enter_req = 1'b0; exit_req = 1'b0; exit_slot = 3'd0; corrupt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_cap", parking_capacity, 8'h00);
    chk("rst_pl", park_location, 8'h00);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_free", free_count, 8);
    chk("rst_full", full, 0);
    chk("rst_err", check_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    // Directed table
    for (int i = 0; i < 18; i++) begin
      txn(vecs[i].is_exit, vecs[i].slot, lat, pl_or, pl_n);
      chk($sformatf("v%0d_slot", i), resp_slot, vecs[i].exp_slot);
      chk($sformatf("v%0d_ok", i), resp_ok, vecs[i].exp_ok);
      chk($sformatf("v%0d_cap", i), parking_capacity, vecs[i].exp_cap);
      chk($sformatf("v%0d_pl", i), pl_or, vecs[i].exp_pl);
      chk($sformatf("v%0d_pl_cycles", i), pl_n, vecs[i].exp_ok ? 1 : 0);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_full", i), full, vecs[i].exp_cap == 8'hFF);
      chk($sformatf("v%0d_free", i), free_count, 8 - $countones(vecs[i].exp_cap));
    end

    // Simultaneous enter + exit(0) from 8'h05: exit first, enter stays pending
    @(negedge clk);
    enter_req = 1'b1; exit_req = 1'b1; exit_slot = 3'd0;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    exit_req = 1'b0;
    wait_resp(lat, pl_or, pl_n);
    chk("sim_exit_slot", resp_slot, 0);
    chk("sim_exit_ok", resp_ok, 1);
    chk("sim_exit_cap", parking_capacity, 8'h04);
    @(negedge clk);
    chk("sim_idle_ready", req_ready, 1);
    @(negedge clk);
    enter_req = 1'b0;
    wait_resp(lat, pl_or, pl_n);
    chk("sim_enter_slot", resp_slot, 0);
    chk("sim_enter_ok", resp_ok, 1);
    chk("sim_enter_cap", parking_capacity, 8'h05);
    chk("sim_enter_lat", lat, 3);

    // Random traffic against an occupancy model
    do_reset();
    occ = 8'h00;
    for (int t = 0; t < 300; t++) begin
      is_exit = ($urandom_range(0, 99) < 45);
      s = 3'($urandom_range(0, 7));
      if (is_exit) begin
        exp_slot = s;
        exp_ok   = occ[s];
      end else begin
        exp_ok = 1'b0; exp_slot = 3'd0;
        for (int b = 0; b < 8; b++)
          if (!exp_ok && !occ[b]) begin exp_ok = 1'b1; exp_slot = 3'(b); end
      end
      exp_pl = exp_ok ? 8'(1 << exp_slot) : 8'h00;
      occ = occ ^ exp_pl;
      txn(is_exit, s, lat, pl_or, pl_n);
      chk($sformatf("r%0d_slot", t), resp_slot, exp_slot);
      chk($sformatf("r%0d_ok", t), resp_ok, exp_ok);
      chk($sformatf("r%0d_cap", t), parking_capacity, occ);
      chk($sformatf("r%0d_pl", t), pl_or, exp_pl);
      chk($sformatf("r%0d_lat", t), lat, exp_ok ? 3 : 2);
      chk($sformatf("r%0d_free", t), free_count, 8 - $countones(occ));
    end

    // Corrupted next-capacity stage
    do_reset();
`ifdef PARK_ALLOC_CHECK_EN
    corrupt = 1'b1;
    txn(1'b0, 3'd0, lat, pl_or, pl_n);
    chk("cor_ok", resp_ok, 0);
    chk("cor_cap", parking_capacity, 8'h00);
    chk("cor_err", check_err, 1);
    chk("cor_lat", lat, 3);
    corrupt = 1'b0;
    txn(1'b0, 3'd0, lat, pl_or, pl_n);
    chk("cor_after_ok", resp_ok, 1);
    chk("cor_after_cap", parking_capacity, 8'h01);
    chk("cor_err_sticky", check_err, 1);
`else
    txn(1'b0, 3'd0, lat, pl_or, pl_n);
    chk("err_tied_low", check_err, 0);
    chk("plain_cap", parking_capacity, 8'h01);
`endif

    // Reset asserted mid-COMMIT
    @(negedge clk);
    enter_req = 1'b1;
    n = 0;
    while (park_location == 8'h00 && n < 20) begin @(negedge clk); n++; end
    chk("mid_in_commit", park_location != 8'h00, 1);
    rst = 1'b1;
    enter_req = 1'b0;
    #1;
    chk("mid_rst_pl", park_location, 8'h00);
    chk("mid_rst_cap", parking_capacity, 8'h00);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_err", check_err, 0);
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("mid_rst_no_resp", seen, 0);
    chk("mid_rst_slot", resp_slot, 0);
    chk("mid_rst_ok", resp_ok, 0);
    chk("mid_rst_free", free_count, 8);
    chk("mid_rst_full", full, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_ready_after", req_ready, 1);
    chk("mid_resp_after", resp_valid, 0);
    txn(1'b0, 3'd0, lat, pl_or, pl_n);
    chk("mid_next_slot", resp_slot, 0);
    chk("mid_next_cap", parking_capacity, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
